// File: rtl/control_sequencer.sv
// control_sequencer: microstep controller for the single-bus datapath
// (PC, MAR, MDR, IR, Y, Z, register file). Fetch runs T0-T3, the opcode
// picks the T4-T6 execute steps, and memory steps wait on mem_ready with a
// bounded wait that ends in a faulted halt.
// Optional feature: define SEQ_SINGLE_STEP_EN to add the step_req input,
// which gates the start of every instruction in T0.
module control_sequencer #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        reset,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic        step_req,
`endif
  input  logic [15:0] IR_IN,
  input  logic        mem_ready,
  output logic        PC_in,
  output logic        PC_out,
  output logic        MAR_in,
  output logic        MDR_in,
  output logic        MDR_out,
  output logic        IR_in,
  output logic        IR_out,
  output logic        Y_in,
  output logic        Y_out,
  output logic        Y_offset_in,
  output logic        Z_in,
  output logic        Z_out,
  output logic [1:0]  ALU_op,
  output logic        R_in,
  output logic        R_out,
  output logic [2:0]  R_sel,
  output logic        mem_read,
  output logic        mem_write,
  output logic        halted,
  output logic        fault
);

  typedef enum logic [2:0] {
    ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_HALT
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_LD   = 4'h3;
  localparam logic [3:0] OP_ST   = 4'h4;
  localparam logic [3:0] OP_BR   = 4'h5;
  localparam logic [3:0] OP_MOV  = 4'h6;
  localparam logic [3:0] OP_HALT = 4'h7;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_INC = 2'b10;

  // Last count value still allowed to wait; one more miss means timeout.
  localparam logic [15:0] WAIT_LAST = 16'(WAIT_LIMIT - 1);

  state_t      state;
  logic [15:0] wait_cnt;
  logic        halted_q;
  logic        fault_q;

  logic [3:0]  opcode;
  logic [2:0]  rd;
  logic [2:0]  rs;
  logic        step_ok;
  logic        wait_expired;
  logic        unused_offset;

  assign opcode = IR_IN[15:12];
  assign rd     = IR_IN[11:9];
  assign rs     = IR_IN[8:6];

  // The low offset bits only matter to the datapath's sign extender.
  assign unused_offset = ^IR_IN[5:0];

`ifdef SEQ_SINGLE_STEP_EN
  assign step_ok = step_req;
`else
  assign step_ok = 1'b1;
`endif

  assign wait_expired = !mem_ready && (wait_cnt == WAIT_LAST);

  // Step sequencing, memory-wait timeout and the sticky halt/fault flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_T0;
      wait_cnt <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      wait_cnt <= '0;
      case (state)
        ST_T0: begin
          if (step_ok) state <= ST_T1;
        end
        ST_T1: begin
          if (mem_ready) begin
            state <= ST_T2;
          end else if (wait_expired) begin
            state    <= ST_HALT;
            halted_q <= 1'b1;
            fault_q  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        ST_T2: state <= ST_T3;
        ST_T3: state <= ST_T4;
        ST_T4: begin
          case (opcode)
            OP_ADD, OP_SUB, OP_LD, OP_ST, OP_BR, OP_MOV: state <= ST_T5;
            OP_HALT: begin
              state    <= ST_HALT;
              halted_q <= 1'b1;
            end
            default: state <= ST_T0;
          endcase
        end
        ST_T5: begin
          case (opcode)
            OP_ADD, OP_SUB, OP_BR: state <= ST_T6;
            OP_LD, OP_ST: begin
              if (mem_ready) begin
                state <= (opcode == OP_LD) ? ST_T6 : ST_T0;
              end else if (wait_expired) begin
                state    <= ST_HALT;
                halted_q <= 1'b1;
                fault_q  <= 1'b1;
              end else begin
                wait_cnt <= wait_cnt + 16'd1;
              end
            end
            default: state <= ST_T0;
          endcase
        end
        ST_T6:   state <= ST_T0;
        ST_HALT: state <= ST_HALT;
        default: state <= ST_T0;
      endcase
    end
  end

  // Strobe decode from the current step and IR_IN; IR is only loaded at the
  // end of T3, so T4 onward must see the live IR_IN rather than a copy taken
  // a cycle earlier. Everything is forced low while reset is held.
  always_comb begin
    PC_in       = 1'b0;
    PC_out      = 1'b0;
    MAR_in      = 1'b0;
    MDR_in      = 1'b0;
    MDR_out     = 1'b0;
    IR_in       = 1'b0;
    IR_out      = 1'b0;
    Y_in        = 1'b0;
    Y_out       = 1'b0;
    Y_offset_in = 1'b0;
    Z_in        = 1'b0;
    Z_out       = 1'b0;
    ALU_op      = ALU_ADD;
    R_in        = 1'b0;
    R_out       = 1'b0;
    R_sel       = 3'd0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    halted      = 1'b0;
    fault       = 1'b0;
    if (!reset) begin
      halted = halted_q;
      fault  = fault_q;
      case (state)
        ST_T0: begin
          if (step_ok) begin
            PC_out   = 1'b1;
            MAR_in   = 1'b1;
            Y_in     = 1'b1;
            mem_read = 1'b1;
          end
        end
        ST_T1: begin
          ALU_op   = ALU_INC;
          Z_in     = 1'b1;
          mem_read = 1'b1;
        end
        ST_T2: begin
          Z_out = 1'b1;
          PC_in = 1'b1;
        end
        ST_T3: begin
          MDR_out = 1'b1;
          IR_in   = 1'b1;
        end
        ST_T4: begin
          case (opcode)
            OP_ADD, OP_SUB, OP_MOV: begin
              R_out = 1'b1;
              R_sel = rs;
              Y_in  = 1'b1;
            end
            OP_LD: begin
              R_out    = 1'b1;
              R_sel    = rs;
              MAR_in   = 1'b1;
              mem_read = 1'b1;
            end
            OP_ST: begin
              R_out  = 1'b1;
              R_sel  = rs;
              MAR_in = 1'b1;
            end
            OP_BR: begin
              IR_out      = 1'b1;
              Y_offset_in = 1'b1;
            end
            default: ;
          endcase
        end
        ST_T5: begin
          case (opcode)
            OP_ADD, OP_SUB: begin
              R_out  = 1'b1;
              R_sel  = rd;
              ALU_op = (opcode == OP_SUB) ? ALU_SUB : ALU_ADD;
              Z_in   = 1'b1;
            end
            OP_LD: mem_read = 1'b1;
            OP_ST: begin
              R_out     = 1'b1;
              R_sel     = rd;
              MDR_in    = 1'b1;
              mem_write = 1'b1;
            end
            OP_BR: begin
              PC_out = 1'b1;
              ALU_op = ALU_ADD;
              Z_in   = 1'b1;
            end
            OP_MOV: begin
              Y_out = 1'b1;
              R_in  = 1'b1;
              R_sel = rd;
            end
            default: ;
          endcase
        end
        ST_T6: begin
          case (opcode)
            OP_ADD, OP_SUB: begin
              Z_out = 1'b1;
              R_in  = 1'b1;
              R_sel = rd;
            end
            OP_LD: begin
              MDR_out = 1'b1;
              R_in    = 1'b1;
              R_sel   = rd;
            end
            OP_BR: begin
              Z_out = 1'b1;
              PC_in = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: checks control_sequencer against a microstep-list
// model. Each instruction expands into a list of expected strobe words; the
// list is consumed one entry per cycle, wait entries repeat until mem_ready.
module tb_control_sequencer;

  localparam int WAIT_LIMIT = 4;

  localparam logic [22:0] S_PC_IN    = 23'h1 << 22;
  localparam logic [22:0] S_PC_OUT   = 23'h1 << 21;
  localparam logic [22:0] S_MAR_IN   = 23'h1 << 20;
  localparam logic [22:0] S_MDR_IN   = 23'h1 << 19;
  localparam logic [22:0] S_MDR_OUT  = 23'h1 << 18;
  localparam logic [22:0] S_IR_IN    = 23'h1 << 17;
  localparam logic [22:0] S_IR_OUT   = 23'h1 << 16;
  localparam logic [22:0] S_Y_IN     = 23'h1 << 15;
  localparam logic [22:0] S_Y_OUT    = 23'h1 << 14;
  localparam logic [22:0] S_YOFF_IN  = 23'h1 << 13;
  localparam logic [22:0] S_Z_IN     = 23'h1 << 12;
  localparam logic [22:0] S_Z_OUT    = 23'h1 << 11;
  localparam logic [22:0] S_R_IN     = 23'h1 << 8;
  localparam logic [22:0] S_R_OUT    = 23'h1 << 7;
  localparam logic [22:0] S_MEM_RD   = 23'h1 << 3;
  localparam logic [22:0] S_MEM_WR   = 23'h1 << 2;
  localparam logic [22:0] S_HALTED   = 23'h1 << 1;
  localparam logic [22:0] S_FAULT    = 23'h1;

  typedef struct packed {
    logic [22:0] vec;
    logic        is_wait;
    logic        load_ir;
    logic        to_halt;
  } step_t;

  logic        clk;
  logic        reset;
  logic [15:0] IR_IN;
  logic        mem_ready;
  logic        PC_in, PC_out, MAR_in, MDR_in, MDR_out, IR_in, IR_out;
  logic        Y_in, Y_out, Y_offset_in, Z_in, Z_out;
  logic [1:0]  ALU_op;
  logic        R_in, R_out;
  logic [2:0]  R_sel;
  logic        mem_read, mem_write, halted, fault;
  logic [22:0] obs;

  int          total_checks = 0;
  int          bad_checks = 0;
  int          cycle_num = 0;

  step_t       step_q[$];
  logic [15:0] instr_q[$];
  logic [15:0] model_ir;
  bit          m_halted;
  bit          m_fault;
  int          wait_cnt;
  bit          ir_pending;

  control_sequencer #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
    .clk(clk),
    .reset(reset),
`ifdef SEQ_SINGLE_STEP_EN
    .step_req(1'b1),
`endif
    .IR_IN(IR_IN),
    .mem_ready(mem_ready),
    .PC_in(PC_in),
    .PC_out(PC_out),
    .MAR_in(MAR_in),
    .MDR_in(MDR_in),
    .MDR_out(MDR_out),
    .IR_in(IR_in),
    .IR_out(IR_out),
    .Y_in(Y_in),
    .Y_out(Y_out),
    .Y_offset_in(Y_offset_in),
    .Z_in(Z_in),
    .Z_out(Z_out),
    .ALU_op(ALU_op),
    .R_in(R_in),
    .R_out(R_out),
    .R_sel(R_sel),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .halted(halted),
    .fault(fault)
  );

  assign obs = {PC_in, PC_out, MAR_in, MDR_in, MDR_out, IR_in, IR_out,
                Y_in, Y_out, Y_offset_in, Z_in, Z_out, ALU_op, R_in, R_out,
                R_sel, mem_read, mem_write, halted, fault};

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [22:0] alu_f(input logic [1:0] op);
    return {12'b0, op, 9'b0};
  endfunction

  function automatic logic [22:0] rsel_f(input logic [2:0] r);
    return {16'b0, r, 4'b0};
  endfunction

  task automatic checkOutput(input string tag, input logic [22:0] observed,
                             input logic [22:0] expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s cycle=%0d got=%h want=%h", tag, cycle_num,
               observed, expected);
    end
  endtask

  task automatic add_step(input logic [22:0] v, input logic w,
                          input logic l, input logic h);
    step_t s;
    s.vec = v;
    s.is_wait = w;
    s.load_ir = l;
    s.to_halt = h;
    step_q.push_back(s);
  endtask

  task automatic push_fetch();
    add_step(S_PC_OUT | S_MAR_IN | S_Y_IN | S_MEM_RD, 1'b0, 1'b0, 1'b0);
    add_step(alu_f(2'b10) | S_Z_IN | S_MEM_RD, 1'b1, 1'b0, 1'b0);
    add_step(S_Z_OUT | S_PC_IN, 1'b0, 1'b0, 1'b0);
    add_step(S_MDR_OUT | S_IR_IN, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic push_exec(input logic [15:0] ir);
    logic [2:0] rd;
    logic [2:0] rs;
    rd = ir[11:9];
    rs = ir[8:6];
    case (ir[15:12])
      4'h1, 4'h2: begin
        add_step(S_R_OUT | rsel_f(rs) | S_Y_IN, 1'b0, 1'b0, 1'b0);
        add_step(S_R_OUT | rsel_f(rd) | S_Z_IN |
                 alu_f((ir[15:12] == 4'h2) ? 2'b01 : 2'b00), 1'b0, 1'b0, 1'b0);
        add_step(S_Z_OUT | S_R_IN | rsel_f(rd), 1'b0, 1'b0, 1'b0);
      end
      4'h3: begin
        add_step(S_R_OUT | rsel_f(rs) | S_MAR_IN | S_MEM_RD, 1'b0, 1'b0, 1'b0);
        add_step(S_MEM_RD, 1'b1, 1'b0, 1'b0);
        add_step(S_MDR_OUT | S_R_IN | rsel_f(rd), 1'b0, 1'b0, 1'b0);
      end
      4'h4: begin
        add_step(S_R_OUT | rsel_f(rs) | S_MAR_IN, 1'b0, 1'b0, 1'b0);
        add_step(S_R_OUT | rsel_f(rd) | S_MDR_IN | S_MEM_WR, 1'b1, 1'b0, 1'b0);
      end
      4'h5: begin
        add_step(S_IR_OUT | S_YOFF_IN, 1'b0, 1'b0, 1'b0);
        add_step(S_PC_OUT | alu_f(2'b00) | S_Z_IN, 1'b0, 1'b0, 1'b0);
        add_step(S_Z_OUT | S_PC_IN, 1'b0, 1'b0, 1'b0);
      end
      4'h6: begin
        add_step(S_R_OUT | rsel_f(rs) | S_Y_IN, 1'b0, 1'b0, 1'b0);
        add_step(S_Y_OUT | S_R_IN | rsel_f(rd), 1'b0, 1'b0, 1'b0);
      end
      4'h7: add_step('0, 1'b0, 1'b0, 1'b1);
      default: add_step('0, 1'b0, 1'b0, 1'b0);
    endcase
  endtask

  task automatic model_reset();
    step_q.delete();
    push_fetch();
    m_halted = 1'b0;
    m_fault = 1'b0;
    wait_cnt = 0;
  endtask

  task automatic model_advance(input bit ready);
    step_t cur;
    if (!m_halted) begin
      cur = step_q[0];
      if (cur.is_wait && !ready) begin
        wait_cnt++;
        if (wait_cnt == WAIT_LIMIT) begin
          m_halted = 1'b1;
          m_fault = 1'b1;
        end
      end else begin
        wait_cnt = 0;
        void'(step_q.pop_front());
        if (cur.to_halt) begin
          m_halted = 1'b1;
        end else begin
          if (cur.load_ir) begin
            if (instr_q.size() != 0) model_ir = instr_q.pop_front();
            else model_ir = 16'($urandom);
            ir_pending = 1'b1;
            push_exec(model_ir);
          end
          if (step_q.size() == 0) push_fetch();
        end
      end
    end
  endtask

  // One clock: drive inputs, check the cycle's strobes, step the model.
  task automatic applyStimulus(input bit rst, input bit ready);
    logic [22:0] expected;
    logic        one_driver;
    reset = rst;
    mem_ready = ready;
    @(negedge clk);
    if (rst) expected = '0;
    else if (m_halted) expected = S_HALTED | (m_fault ? S_FAULT : 23'h0);
    else expected = step_q[0].vec;
    checkOutput(rst ? "reset" : (m_halted ? "halt" : "strobes"), obs, expected);
    one_driver = ($countones({PC_out, MDR_out, IR_out, Y_out, Z_out, R_out}) <= 1);
    checkOutput("bus_drivers", {22'b0, one_driver}, 23'h1);
    ir_pending = 1'b0;
    if (rst) model_reset();
    else model_advance(ready);
    @(posedge clk);
    #1;
    if (ir_pending) IR_IN = model_ir;
    cycle_num++;
  endtask

  // Directed program, timeout case, then a long randomized run.
  initial begin
    int  low_left;
    int  halt_cycles;
    bit  ready;
    bit  rst;
    reset = 1'b1;
    mem_ready = 1'b0;
    IR_IN = 16'h0000;
    model_ir = 16'h0000;
    ir_pending = 1'b0;
    model_reset();

    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    instr_q = '{16'h1280, 16'h51FE, 16'h3440, 16'hF123, 16'h4A80,
                16'h6500, 16'h2A40, 16'h7000};
    low_left = WAIT_LIMIT - 1;
    for (int i = 0; i < 90; i++) begin
      ready = 1'b1;
      if (!m_halted && step_q.size() != 0 && step_q[0].is_wait && low_left > 0) begin
        ready = 1'b0;
        low_left--;
      end
      applyStimulus(1'b0, ready);
      if (ir_pending && model_ir[15:12] == 4'h3) low_left = WAIT_LIMIT - 1;
    end

    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);

    halt_cycles = 0;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0) || (m_halted && halt_cycles >= 12);
      ready = ($urandom_range(0, 99) < 75);
      applyStimulus(rst, ready);
      halt_cycles = m_halted ? halt_cycles + 1 : 0;
    end

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
